l2_interleave_router: RTL and testbench
=======================================

// Module: l2_interleave_router
// PURPOSE
// Routes one upstream L2 request stream (cache refill/writeback) to NumChannels DRAM channels.
// Translates each address with a runtime-selectable interleave granularity (or contiguous mapping).
// Returns responses upstream strictly in request order. Locally answers out-of-range requests with an error.
// Sits between the cache-controller xbar and the per-channel DRAM controllers in cachepool_cluster.
// PARAMETERS
// NumChannels     4             DRAM channels; power of 2, >=2; S = $clog2(NumChannels)
// AddrWidth       32            address width (AW)
// DataWidth       256           data width; StrbWidth = DataWidth/8
// UserWidth       8             opaque user field, passed through with the request
// DramBase        32'h8000_0000 first DRAM byte address
// ChanSizeLog2    28            log2 of bytes per channel (CS)
// MaxOutstanding  16            order-FIFO depth = max in-flight requests incl. error entries
// MinIlvLog2      5             smallest legal interleave log2 (one 32-byte beat)
// MaxIlvLog2      16            largest legal interleave log2
// PORTS
// clk_i            in   1                clock
// rst_i            in   1                synchronous reset, active-high
// cfg_ilv_log2_i   in   5                requested interleave log2, clamped to [MinIlvLog2,MaxIlvLog2]
// cfg_scramble_i   in   1                1: interleaved mapping; 0: contiguous mapping
// busy_o           out  1                in-flight work present (order FIFO or channel q-stages non-empty)
// req_q_valid_i    in   1                upstream request valid
// req_q_ready_o    out  1                upstream request ready
// req_q_i          in   struct           {addr[AW], write, data, strb, user}
// rsp_p_valid_o    out  1                upstream response valid
// rsp_p_ready_i    in   1                upstream response ready
// rsp_p_o          out  struct           {data, error, user}
// ch_q_valid_o     out  NumChannels      per-channel request valid
// ch_q_ready_i     in   NumChannels      per-channel request ready
// ch_q_o           out  [NumChannels]    per-channel {addr[AW] channel-local, write, data, strb, user}
// ch_p_valid_i     in   NumChannels      per-channel response valid (one per request, reads and writes)
// ch_p_ready_o     out  NumChannels      per-channel response ready
// ch_p_i           in   [NumChannels]    per-channel {data, error, user}
// BEHAVIOUR
// - Reset: all valids=0, req_q_ready_o=0 during reset, busy_o=0, order FIFO empty, active cfg = {MinIlvLog2, 1}.
// - Translation (off = addr - DramBase, unsigned, AW bits):
//   - in range iff addr>=DramBase && off < NumChannels<<CS.
//   - scramble=1, C = active ilv: ch = off[C+S-1:C]; ch_addr = {S'b0, off[AW-1:C+S], off[C-1:0]}.
//   - scramble=0: ch = off[CS+S-1:CS]; ch_addr = off & ((1<<CS)-1).
//   - AW-wide arithmetic throughout; no carries beyond AW.
// - Active cfg: captures cfg_* only in cycles where busy_o=0 and no handshake is occurring. Otherwise it is held, so a mapping change never splits in-flight traffic.
// - Request accept: req_q_ready_o = !fifo_full && (out-of-range || q-stage[ch] empty or draining this cycle).
//   - On accept: push {err, ch} into the order FIFO.
//   - In range: load q-stage[ch]. Registered, 1-cycle min latency; ch_q_valid_o[ch] rises the cycle after accept.
//   - Out of range: no channel traffic.
// - Channel q-stage: holds while valid && !ready; clears on handshake; accept+drain in the same cycle keeps it full (full throughput).
// - Response ordering: FIFO head selects the source.
//   - Head err=1: rsp_p_valid_o=1, error=1, data=0, user = captured request user (user field stored in FIFO).
//   - Head err=0: rsp_p_o = ch_p_i[head.ch]; rsp_p_valid_o = ch_p_valid_i[head.ch]; ch_p_ready_o[head.ch] = rsp_p_ready_i; all other ch_p_ready_o=0.
//   - Pop the FIFO on the upstream response handshake. Response path is combinational (0 cycles).
// - FIFO full: req_q_ready_o=0. Push and pop in the same cycle while full is legal and keeps it full.
// - Reset mid-operation: drops all queued state, no responses emitted; downstream is reset together.
// - Responses from non-head channels are back-pressured; no reordering buffer.
// STRUCTURE
// - cachepool_pkg: l2_req_t/l2_rsp_t via REQRSP typedef, ilv_cfg_t, order_entry_t {err, ch, user}.
// - cachepool_pkg: function l2_ilv_xlate(addr, cfg) returning {in_range, ch, ch_addr}; shared with the bench model.
// - Order FIFO: common_cells fifo_v3 (DEPTH=MaxOutstanding, FALL_THROUGH=0).
// - Channel q-stages: inline generate loop. No further sub-modules.
// TESTING
// - ilv=9, scramble=1: writes to 0x8000_0000, 0x8000_0200, 0x8000_0400, 0x8000_0800 -> ch 0,1,2,0; ch_addr 0x0,0x0,0x0,0x200.
// - scramble=0: read 0x9000_0010 -> ch1, ch_addr 0x10. Read 0x7FFF_FFF0 -> no channel valid, rsp error=1, data=0.
// - Ordering: reads to ch0 then ch1; ch1 responds first -> ch1 stalled (ch_p_ready_o[1]=0) until ch0 response delivered.
// - 16 reads, all ch_p_valid_i=0 -> 17th request sees req_q_ready_o=0; one response frees exactly one slot.
// - ch_q_ready_i[2]=0 for 5 cycles with back-to-back ch2 requests -> one held in stage, next blocked, no loss/dup.
// - Change cfg_ilv_log2_i 9->12 while busy -> old mapping used until busy_o=0; next accepted request uses 12.

Source files
------------

// File: rtl/l2_interleave_router_pkg.sv
// Shared types, geometry and address translation for the L2 -> DRAM channel router.
package l2_interleave_router_pkg;

  localparam int unsigned NumChannels    = 4;
  localparam int unsigned ChanSel        = $clog2(NumChannels);
  localparam int unsigned AddrWidth      = 32;
  localparam int unsigned DataWidth      = 256;
  localparam int unsigned StrbWidth      = DataWidth / 8;
  localparam int unsigned UserWidth      = 8;
  localparam int unsigned ChanSizeLog2   = 28;
  localparam int unsigned MaxOutstanding = 16;
  localparam int unsigned MinIlvLog2     = 5;
  localparam int unsigned MaxIlvLog2     = 16;
  localparam int unsigned IlvWidth       = 5;
  localparam logic [AddrWidth-1:0] DramBase = 32'h8000_0000;

  typedef logic [ChanSel-1:0] ch_idx_t;

  typedef enum logic {
    MapContig = 1'b0,
    MapIlv    = 1'b1
  } map_mode_t;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 write;
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic [UserWidth-1:0] user;
  } l2_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic                 error;
    logic [UserWidth-1:0] user;
  } l2_rsp_t;

  typedef struct packed {
    logic [IlvWidth-1:0] ilv_log2;
    map_mode_t           mode;
  } ilv_cfg_t;

  typedef struct packed {
    logic                 err;
    ch_idx_t              ch;
    logic [UserWidth-1:0] user;
  } order_entry_t;

  typedef struct packed {
    logic                 in_range;
    ch_idx_t              ch;
    logic [AddrWidth-1:0] ch_addr;
  } xlate_t;

  function automatic logic [IlvWidth-1:0] clamp_ilv(input logic [IlvWidth-1:0] v);
    logic [IlvWidth-1:0] r;
    r = v;
    if (v < IlvWidth'(MinIlvLog2)) r = IlvWidth'(MinIlvLog2);
    if (v > IlvWidth'(MaxIlvLog2)) r = IlvWidth'(MaxIlvLog2);
    return r;
  endfunction

  // Interleaved: channel bits sit just above the granule offset and are squeezed out of ch_addr.
  function automatic xlate_t l2_ilv_xlate(input logic [AddrWidth-1:0] addr, input ilv_cfg_t cfg);
    xlate_t               res;
    logic [AddrWidth-1:0] off;
    logic [AddrWidth-1:0] sel;
    logic [AddrWidth-1:0] lo_mask;
    res          = '0;
    off          = addr - DramBase;
    res.in_range = (addr >= DramBase) && ((off >> (ChanSizeLog2 + ChanSel)) == '0);
    if (cfg.mode == MapIlv) begin
      sel         = off >> cfg.ilv_log2;
      lo_mask     = (AddrWidth'(1) << cfg.ilv_log2) - AddrWidth'(1);
      res.ch_addr = ((off >> (cfg.ilv_log2 + IlvWidth'(ChanSel))) << cfg.ilv_log2) | (off & lo_mask);
    end else begin
      sel         = off >> ChanSizeLog2;
      res.ch_addr = off & ((AddrWidth'(1) << ChanSizeLog2) - AddrWidth'(1));
    end
    res.ch = sel[ChanSel-1:0];
    return res;
  endfunction

endpackage

// File: rtl/l2_interleave_router_fifo.sv
// Order FIFO holding {err, ch, user} per accepted request; registered output, no fall-through.
module l2_interleave_router_fifo
  import l2_interleave_router_pkg::*;
#(
  parameter int unsigned Depth = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  order_entry_t data_i,
  input  logic         pop_i,
  output order_entry_t data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  order_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            push_ok, pop_ok;

  always_comb begin
    full_o   = (cnt_q == CntW'(Depth));
    empty_o  = (cnt_q == '0);
    pop_ok   = pop_i && !empty_o;
    push_ok  = push_i && (!full_o || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    cnt_d  = cnt_q + CntW'(push_ok) - CntW'(pop_ok);
    data_o = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/l2_interleave_router.sv
// Routes L2 requests to interleaved DRAM channels and returns responses in request order.
module l2_interleave_router
  import l2_interleave_router_pkg::*;
(
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [IlvWidth-1:0]               cfg_ilv_log2_i,
  input  logic                              cfg_scramble_i,
  output logic                              busy_o,
  input  logic                              req_q_valid_i,
  output logic                              req_q_ready_o,
  input  l2_req_t                           req_q_i,
  output logic                              rsp_p_valid_o,
  input  logic                              rsp_p_ready_i,
  output l2_rsp_t                           rsp_p_o,
  output logic [NumChannels-1:0]            ch_q_valid_o,
  input  logic [NumChannels-1:0]            ch_q_ready_i,
  output l2_req_t [NumChannels-1:0]         ch_q_o,
  input  logic [NumChannels-1:0]            ch_p_valid_i,
  output logic [NumChannels-1:0]            ch_p_ready_o,
  input  l2_rsp_t [NumChannels-1:0]         ch_p_i
);

  ilv_cfg_t                  cfg_q, cfg_d;
  logic [NumChannels-1:0]    stage_valid_q, stage_valid_d;
  l2_req_t [NumChannels-1:0] stage_q, stage_d;
  logic [NumChannels-1:0]    stage_free;
  xlate_t                    xl;
  order_entry_t              fifo_head, fifo_wdata;
  logic                      fifo_full, fifo_empty;
  logic                      req_hs, rsp_hs;

  l2_interleave_router_fifo #(
    .Depth (MaxOutstanding)
  ) u_order_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (req_hs),
    .data_i  (fifo_wdata),
    .pop_i   (rsp_hs),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    xl            = l2_ilv_xlate(req_q_i.addr, cfg_q);
    stage_free    = ~stage_valid_q | ch_q_ready_i;
    req_q_ready_o = !rst_i && !fifo_full && (!xl.in_range || stage_free[xl.ch]);
    req_hs        = req_q_valid_i && req_q_ready_o;
    fifo_wdata    = '{err: !xl.in_range, ch: xl.ch, user: req_q_i.user};
    busy_o        = !fifo_empty || (|stage_valid_q);
    ch_q_valid_o  = stage_valid_q;
    ch_q_o        = stage_q;
  end

  // The FIFO head alone decides which channel may hand a response upstream.
  always_comb begin
    rsp_p_valid_o = 1'b0;
    rsp_p_o       = '0;
    ch_p_ready_o  = '0;
    if (!fifo_empty) begin
      if (fifo_head.err) begin
        rsp_p_valid_o = 1'b1;
        rsp_p_o.error = 1'b1;
        rsp_p_o.user  = fifo_head.user;
      end else begin
        rsp_p_valid_o                = ch_p_valid_i[fifo_head.ch];
        rsp_p_o                      = ch_p_i[fifo_head.ch];
        ch_p_ready_o[fifo_head.ch]   = rsp_p_ready_i;
      end
    end
    rsp_hs = rsp_p_valid_o && rsp_p_ready_i;
  end

  always_comb begin
    stage_valid_d = stage_valid_q & ~ch_q_ready_i;
    stage_d       = stage_q;
    for (int unsigned c = 0; c < NumChannels; c++) begin
      if (req_hs && xl.in_range && (xl.ch == ch_idx_t'(c))) begin
        stage_valid_d[c]   = 1'b1;
        stage_d[c]         = req_q_i;
        stage_d[c].addr    = xl.ch_addr;
      end
    end
  end

  // Mapping only changes when nothing is in flight and nothing is handshaking this cycle.
  always_comb begin
    cfg_d = cfg_q;
    if (!busy_o && !req_hs && !rsp_hs) begin
      cfg_d = '{ilv_log2: clamp_ilv(cfg_ilv_log2_i), mode: map_mode_t'(cfg_scramble_i)};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_q         <= '{ilv_log2: IlvWidth'(MinIlvLog2), mode: MapIlv};
      stage_valid_q <= '0;
      stage_q       <= '0;
    end else begin
      cfg_q         <= cfg_d;
      stage_valid_q <= stage_valid_d;
      stage_q       <= stage_d;
    end
  end

endmodule

// File: tb/tb_l2_interleave_router.sv
// Randomized scoreboard bench for l2_interleave_router with directed mapping/ordering scenarios.
module tb_l2_interleave_router;
  import l2_interleave_router_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [IlvWidth-1:0]       cfg_ilv_log2_i;
  logic                      cfg_scramble_i;
  logic                      busy_o;
  logic                      req_q_valid_i;
  logic                      req_q_ready_o;
  l2_req_t                   req_q_i;
  logic                      rsp_p_valid_o;
  logic                      rsp_p_ready_i;
  l2_rsp_t                   rsp_p_o;
  logic [NumChannels-1:0]    ch_q_valid_o;
  logic [NumChannels-1:0]    ch_q_ready_i;
  l2_req_t [NumChannels-1:0] ch_q_o;
  logic [NumChannels-1:0]    ch_p_valid_i;
  logic [NumChannels-1:0]    ch_p_ready_o;
  l2_rsp_t [NumChannels-1:0] ch_p_i;

  l2_interleave_router dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cfg_ilv_log2_i (cfg_ilv_log2_i),
    .cfg_scramble_i (cfg_scramble_i),
    .busy_o         (busy_o),
    .req_q_valid_i  (req_q_valid_i),
    .req_q_ready_o  (req_q_ready_o),
    .req_q_i        (req_q_i),
    .rsp_p_valid_o  (rsp_p_valid_o),
    .rsp_p_ready_i  (rsp_p_ready_i),
    .rsp_p_o        (rsp_p_o),
    .ch_q_valid_o   (ch_q_valid_o),
    .ch_q_ready_i   (ch_q_ready_i),
    .ch_q_o         (ch_q_o),
    .ch_p_valid_i   (ch_p_valid_i),
    .ch_p_ready_o   (ch_p_ready_o),
    .ch_p_i         (ch_p_i)
  );

  typedef struct {
    bit      err;
    int      ch;
    l2_rsp_t rsp;
  } ord_t;

  typedef struct {
    int          ch;
    logic [31:0] addr;
  } obs_t;

  int      n_checks = 0;
  int      n_fail   = 0;
  ord_t    ord_q[$];
  l2_req_t exp_chq[NumChannels][$];
  l2_req_t ch_pend[NumChannels][$];
  l2_req_t req_src[$];
  l2_rsp_t rsp_log[$];
  obs_t    chq_log[$];

  int m_ilv;
  bit m_scr;
  int rdy_prob[NumChannels];
  int rsp_prob[NumChannels];
  int up_rdy_prob;
  int req_prob;
  int rsp_budget;
  bit rand_on;
  int n_acc;
  bit req_hs_s;
  logic [NumChannels-1:0] chp_hs_s;

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v);
    if (v < int'(MinIlvLog2)) return int'(MinIlvLog2);
    if (v > int'(MaxIlvLog2)) return int'(MaxIlvLog2);
    return v;
  endfunction

  // Reference mapping with plain integer arithmetic: block index modulo channel count.
  function automatic void model_xlate(input logic [31:0] addr, input int ilv, input bit scr,
                                      output bit inr, output int ch, output logic [31:0] ca);
    longint off, gran, blk;
    off = longint'(addr) - longint'(32'h8000_0000);
    inr = (off >= 0) && (off < (longint'(NumChannels) << ChanSizeLog2));
    ch  = 0;
    ca  = '0;
    if (inr) begin
      if (scr) begin
        gran = longint'(1) << ilv;
        blk  = off / gran;
        ch   = int'(blk % NumChannels);
        ca   = 32'((blk / NumChannels) * gran + off % gran);
      end else begin
        ch = int'(off >> ChanSizeLog2);
        ca = 32'(off % (longint'(1) << ChanSizeLog2));
      end
    end
  endfunction

  function automatic l2_rsp_t chan_rsp(input int c, input l2_req_t r);
    l2_rsp_t     p;
    logic [31:0] w;
    w       = r.addr ^ (32'(c) << 28) ^ {24'h0, r.user} ^ 32'h1234_5678;
    p.data  = {8{w}};
    p.error = r.addr[6] ^ r.write;
    p.user  = r.user;
    return p;
  endfunction

  function automatic l2_req_t mk_req(input logic [31:0] addr, input bit wr, input logic [7:0] user);
    l2_req_t r;
    r.addr  = addr;
    r.write = wr;
    for (int i = 0; i < 8; i++) r.data[i*32 +: 32] = $urandom;
    r.strb  = $urandom;
    r.user  = user;
    return r;
  endfunction

  function automatic l2_req_t rand_req();
    int          kind;
    logic [31:0] a;
    kind = int'($urandom_range(0, 9));
    if (kind == 0)      a = $urandom_range(0, 32'h7FFF_FFFF);
    else if (kind == 1) a = 32'hC000_0000 + $urandom_range(0, 32'h3FFF_FFFF);
    else                a = 32'h8000_0000 + ($urandom & 32'h3FFF_FFFF);
    return mk_req(a, 1'($urandom_range(0, 1)), 8'($urandom));
  endfunction

  task automatic observe();
    bit          busy0, inr, exp_rv, exp_pr, exp_rdy, rsp_hs;
    int          ch;
    logic [31:0] ca;
    l2_req_t     cr;
    ord_t        e;
    busy0 = (ord_q.size() != 0);
    check_eq("busy", 512'(busy_o), 512'(busy0));
    for (int c = 0; c < NumChannels; c++)
      check_eq("ch_q_valid", 512'(ch_q_valid_o[c]), 512'(exp_chq[c].size() != 0));
    exp_rv = busy0 && (ord_q[0].err || ch_p_valid_i[ord_q[0].ch]);
    check_eq("rsp_valid", 512'(rsp_p_valid_o), 512'(exp_rv));
    for (int c = 0; c < NumChannels; c++) begin
      exp_pr = busy0 && !ord_q[0].err && (ord_q[0].ch == c) && rsp_p_ready_i;
      check_eq("ch_p_ready", 512'(ch_p_ready_o[c]), 512'(exp_pr));
    end
    if (req_q_valid_i) begin
      model_xlate(req_q_i.addr, m_ilv, m_scr, inr, ch, ca);
      exp_rdy = (ord_q.size() < MaxOutstanding) &&
                (!inr || exp_chq[ch].size() == 0 || ch_q_ready_i[ch]);
      check_eq("req_ready", 512'(req_q_ready_o), 512'(exp_rdy));
    end
    for (int c = 0; c < NumChannels; c++) begin
      if (ch_q_valid_o[c] && ch_q_ready_i[c] && exp_chq[c].size() != 0) begin
        cr = exp_chq[c].pop_front();
        check_eq("ch_q_o", 512'(ch_q_o[c]), 512'(cr));
        ch_pend[c].push_back(cr);
        chq_log.push_back('{c, ch_q_o[c].addr});
      end
    end
    rsp_hs = rsp_p_valid_o && rsp_p_ready_i;
    if (rsp_hs && ord_q.size() != 0) begin
      e = ord_q.pop_front();
      check_eq("rsp_p_o", 512'(rsp_p_o), 512'(e.rsp));
      rsp_log.push_back(rsp_p_o);
    end
    req_hs_s = req_q_valid_i && req_q_ready_o;
    if (req_hs_s) begin
      n_acc++;
      model_xlate(req_q_i.addr, m_ilv, m_scr, inr, ch, ca);
      if (inr) begin
        cr      = req_q_i;
        cr.addr = ca;
        exp_chq[ch].push_back(cr);
        ord_q.push_back('{1'b0, ch, chan_rsp(ch, cr)});
      end else begin
        ord_q.push_back('{1'b1, 0, '{data: '0, error: 1'b1, user: req_q_i.user}});
      end
    end
    chp_hs_s = ch_p_valid_i & ch_p_ready_o;
    if (!busy0 && !req_hs_s && !rsp_hs) begin
      m_ilv = clampi(int'(cfg_ilv_log2_i));
      m_scr = cfg_scramble_i;
    end
  endtask

  task automatic drive();
    if (req_hs_s) req_q_valid_i = 1'b0;
    if (!req_q_valid_i) begin
      if (req_src.size() != 0) begin
        req_q_i       = req_src.pop_front();
        req_q_valid_i = 1'b1;
      end else if (rand_on && int'($urandom_range(0, 99)) < req_prob) begin
        req_q_i       = rand_req();
        req_q_valid_i = 1'b1;
      end
    end
    for (int c = 0; c < NumChannels; c++) begin
      ch_q_ready_i[c] = int'($urandom_range(0, 99)) < rdy_prob[c];
      if (chp_hs_s[c]) begin
        void'(ch_pend[c].pop_front());
        ch_p_valid_i[c] = 1'b0;
      end
      if (!ch_p_valid_i[c] && ch_pend[c].size() != 0 && rsp_budget != 0 &&
          int'($urandom_range(0, 99)) < rsp_prob[c]) begin
        ch_p_valid_i[c] = 1'b1;
        ch_p_i[c]       = chan_rsp(c, ch_pend[c][0]);
        if (rsp_budget > 0) rsp_budget--;
      end
    end
    rsp_p_ready_i = int'($urandom_range(0, 99)) < up_rdy_prob;
    if (rand_on && $urandom_range(0, 99) < 2) begin
      cfg_ilv_log2_i = 5'($urandom_range(0, 31));
      cfg_scramble_i = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic cycle();
    observe();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while ((ord_q.size() != 0 || req_src.size() != 0 || req_q_valid_i) && k < bound) begin
      cycle();
      k++;
    end
    check_eq("drain_busy", 512'(busy_o), 512'(0));
  endtask

  task automatic set_all(input int rdy, input int rsp);
    for (int c = 0; c < NumChannels; c++) begin
      rdy_prob[c] = rdy;
      rsp_prob[c] = rsp;
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    req_q_i       = mk_req(32'h8000_0040, 1'b0, 8'h0);
    req_q_valid_i = 1'b1;
    ch_q_ready_i  = '0;
    ch_p_valid_i  = '0;
    ch_p_i        = '0;
    rsp_p_ready_i = 1'b1;
    req_hs_s      = 1'b0;
    chp_hs_s      = '0;
    rsp_budget    = -1;
    ord_q.delete();
    req_src.delete();
    for (int c = 0; c < NumChannels; c++) begin
      exp_chq[c].delete();
      ch_pend[c].delete();
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", 512'(req_q_ready_o), 512'(0));
    check_eq("rst_busy", 512'(busy_o), 512'(0));
    check_eq("rst_rsp_valid", 512'(rsp_p_valid_o), 512'(0));
    check_eq("rst_ch_q_valid", 512'(ch_q_valid_o), 512'(0));
    @(posedge clk);
    #1;
    rst           = 1'b0;
    req_q_valid_i = 1'b0;
    m_ilv         = int'(MinIlvLog2);
    m_scr         = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int          base, n0, e_ch[4];
    logic [31:0] e_ad[4];
    up_rdy_prob    = 100;
    req_prob       = 0;
    rand_on        = 1'b0;
    n_acc          = 0;
    cfg_ilv_log2_i = 5'd9;
    cfg_scramble_i = 1'b1;
    set_all(100, 100);
    do_reset();
    run(2);

    // ilv=9 interleaved writes
    base = chq_log.size();
    req_src.push_back(mk_req(32'h8000_0000, 1'b1, 8'h11));
    req_src.push_back(mk_req(32'h8000_0200, 1'b1, 8'h12));
    req_src.push_back(mk_req(32'h8000_0400, 1'b1, 8'h13));
    req_src.push_back(mk_req(32'h8000_0800, 1'b1, 8'h14));
    drain(200);
    e_ch = '{0, 1, 2, 0};
    e_ad = '{32'h0, 32'h0, 32'h0, 32'h200};
    for (int i = 0; i < 4; i++) begin
      check_eq("s1_ch", 512'(chq_log[base+i].ch), 512'(e_ch[i]));
      check_eq("s1_addr", 512'(chq_log[base+i].addr), 512'(e_ad[i]));
    end

    // contiguous mapping and out-of-range error
    cfg_scramble_i = 1'b0;
    run(3);
    base = chq_log.size();
    req_src.push_back(mk_req(32'h9000_0010, 1'b0, 8'h21));
    req_src.push_back(mk_req(32'h7FFF_FFF0, 1'b0, 8'h22));
    drain(200);
    check_eq("s2_nchq", 512'(chq_log.size() - base), 512'(1));
    check_eq("s2_ch", 512'(chq_log[base].ch), 512'(1));
    check_eq("s2_addr", 512'(chq_log[base].addr), 512'(32'h10));
    check_eq("s2_err", 512'(rsp_log[$].error), 512'(1));
    check_eq("s2_data", 512'(rsp_log[$].data), 512'(0));
    check_eq("s2_user", 512'(rsp_log[$].user), 512'(8'h22));

    // ch1 answers before ch0 and must wait
    rsp_prob[0] = 0;
    req_src.push_back(mk_req(32'h8000_0000, 1'b0, 8'h31));
    req_src.push_back(mk_req(32'h9000_0000, 1'b0, 8'h32));
    run(10);
    check_eq("s3_ch1_stall", 512'(ch_p_ready_o[1]), 512'(0));
    check_eq("s3_rsp_valid", 512'(rsp_p_valid_o), 512'(0));
    rsp_prob[0] = 100;
    drain(200);
    check_eq("s3_first", 512'(rsp_log[rsp_log.size()-2].user), 512'(8'h31));
    check_eq("s3_second", 512'(rsp_log[rsp_log.size()-1].user), 512'(8'h32));

    // order FIFO fills at 16 outstanding
    set_all(100, 0);
    n0 = n_acc;
    for (int i = 0; i < 18; i++)
      req_src.push_back(mk_req(32'h8000_0000 + ($urandom & 32'h3FFF_FFE0), 1'b0, 8'(8'h40 + i)));
    run(40);
    check_eq("s4_acc16", 512'(n_acc - n0), 512'(16));
    check_eq("s4_full_ready", 512'(req_q_ready_o), 512'(0));
    rsp_budget = 1;
    rsp_prob[ord_q[0].ch] = 100;
    run(20);
    check_eq("s4_acc17", 512'(n_acc - n0), 512'(17));
    check_eq("s4_full_again", 512'(req_q_ready_o), 512'(0));
    rsp_budget = -1;
    set_all(100, 100);
    drain(500);

    // ch2 back-pressure with back-to-back ch2 requests
    rdy_prob[2] = 0;
    n0 = n_acc;
    for (int i = 0; i < 3; i++)
      req_src.push_back(mk_req(32'hA000_0000 + 32'(i * 64), 1'b0, 8'(8'h50 + i)));
    run(5);
    check_eq("s5_acc1", 512'(n_acc - n0), 512'(1));
    check_eq("s5_held", 512'(ch_q_valid_o[2]), 512'(1));
    check_eq("s5_blocked", 512'(req_q_ready_o), 512'(0));
    rdy_prob[2] = 100;
    drain(200);

    // cfg change while busy is deferred until idle
    cfg_scramble_i = 1'b1;
    cfg_ilv_log2_i = 5'd9;
    run(3);
    base = chq_log.size();
    set_all(100, 0);
    req_src.push_back(mk_req(32'h8000_1000, 1'b0, 8'h61));
    run(4);
    cfg_ilv_log2_i = 5'd12;
    req_src.push_back(mk_req(32'h8000_1000, 1'b0, 8'h62));
    run(4);
    set_all(100, 100);
    drain(200);
    run(2);
    req_src.push_back(mk_req(32'h8000_1000, 1'b0, 8'h63));
    drain(200);
    check_eq("s6_old_ch_a", 512'(chq_log[base].ch), 512'(0));
    check_eq("s6_old_addr_a", 512'(chq_log[base].addr), 512'(32'h400));
    check_eq("s6_old_ch_b", 512'(chq_log[base+1].ch), 512'(0));
    check_eq("s6_old_addr_b", 512'(chq_log[base+1].addr), 512'(32'h400));
    check_eq("s6_new_ch", 512'(chq_log[base+2].ch), 512'(1));
    check_eq("s6_new_addr", 512'(chq_log[base+2].addr), 512'(32'h0));

    // reset while traffic is queued
    set_all(100, 0);
    for (int i = 0; i < 3; i++) req_src.push_back(rand_req());
    run(6);
    do_reset();
    set_all(100, 100);
    run(2);

    // randomized traffic
    for (int c = 0; c < NumChannels; c++) begin
      rdy_prob[c] = int'($urandom_range(50, 100));
      rsp_prob[c] = int'($urandom_range(30, 100));
    end
    up_rdy_prob = 70;
    req_prob    = 60;
    rand_on     = 1'b1;
    run(3000);
    rand_on = 1'b0;
    set_all(100, 100);
    up_rdy_prob = 100;
    drain(3000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
